// File: rtl/signed_subtractor_pipe_pkg.sv
// Shared helpers for the saturating signed pipelines: width helper and
// two's-complement clamp evaluated on a wide signed carrier.
package signed_subtractor_pipe_pkg;

  // Carrier width for clamp arithmetic; supports operand/result widths up to 128.
  localparam int SAT_VW = 130;

  typedef logic signed [SAT_VW-1:0] sat_val_t;

  typedef struct packed {
    sat_val_t value;
    logic     pos;
    logic     neg;
  } sat_res_t;

  function automatic int max3(int x, int y, int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  function automatic sat_val_t sat_max(int width);
    return (sat_val_t'(1) <<< (width - 1)) - sat_val_t'(1);
  endfunction

  function automatic sat_val_t sat_min(int width);
    return ~sat_max(width);
  endfunction

  function automatic sat_res_t sat_clamp(sat_val_t value, int width);
    sat_res_t r;
    r.value = value;
    r.pos   = 1'b0;
    r.neg   = 1'b0;
    if (value > sat_max(width)) begin
      r.value = sat_max(width);
      r.pos   = 1'b1;
    end else if (value < sat_min(width)) begin
      r.value = sat_min(width);
      r.neg   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_clamp_signed.sv
// Combinational clamp of a signed IN_W-bit value into OUT_W-bit two's-complement
// range, flagging which bound was hit.
module sat_clamp_signed
  import signed_subtractor_pipe_pkg::*;
#(
  parameter int IN_W  = 34,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat_pos,
  output logic             sat_neg
);

  sat_val_t                wide;
  logic [SAT_VW-OUT_W-1:0] clamp_unused_hi;

  always_comb begin
    wide = {{(SAT_VW-IN_W){din[IN_W-1]}}, din};
    {clamp_unused_hi, dout, sat_pos, sat_neg} = sat_clamp(wide, OUT_W);
  end

endmodule

// File: rtl/signed_subtractor_pipe.sv
// Two-stage pipelined saturating signed subtractor (out = a - b) with
// valid/ready backpressure and a sticky saturation monitor.
module signed_subtractor_pipe
  import signed_subtractor_pipe_pkg::*;
#(
  parameter int IN1_WIDTH = 32,
  parameter int IN2_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN1_WIDTH-1:0] a,
  input  logic [IN2_WIDTH-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 sat_pos,
  output logic                 sat_neg,
  input  logic                 sat_clear,
  output logic                 sat_sticky,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int W = max3(IN1_WIDTH, IN2_WIDTH, OUT_WIDTH) + 1;

  logic         s1_valid;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [W:0]   diff;
  logic [OUT_WIDTH-1:0] clamp_out;
  logic         clamp_pos;
  logic         clamp_neg;
  logic         s1_adv;
  logic         s2_adv;
  logic         sat_evt;

  // Handshake: a stage advances when it is empty or the stage after it
  // advances; data moves on valid && ready and stalled stages hold. in_ready
  // is combinational from out_ready (no skid buffer).
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign diff = {s1_a[W-1], s1_a} - {s1_b[W-1], s1_b};

  sat_clamp_signed #(
    .IN_W  (W + 1),
    .OUT_W (OUT_WIDTH)
  ) u_clamp (
    .din     (diff),
    .dout    (clamp_out),
    .sat_pos (clamp_pos),
    .sat_neg (clamp_neg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= {{(W-IN1_WIDTH){a[IN1_WIDTH-1]}}, a};
        s1_b <= {{(W-IN2_WIDTH){b[IN2_WIDTH-1]}}, b};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      sat_pos   <= 1'b0;
      sat_neg   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out     <= clamp_out;
        sat_pos <= clamp_pos;
        sat_neg <= clamp_neg;
      end
    end
  end

  // A held result is counted only on the edge where it actually leaves.
  assign sat_evt = out_valid && out_ready && (sat_pos || sat_neg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (sat_clear) begin
      sat_sticky <= sat_evt;
      sat_count  <= sat_evt ? CNT_WIDTH'(1) : '0;
    end else if (sat_evt) begin
      sat_sticky <= 1'b1;
      if (sat_count != {CNT_WIDTH{1'b1}}) sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_signed_subtractor_pipe.sv
// Bench for signed_subtractor_pipe at 8-bit data, 2-bit counter: table vectors,
// directed backpressure/monitor/reset sequences, and randomized traffic.
module tb_signed_subtractor_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       sat_pos;
  logic       sat_neg;
  logic       sat_clear;
  logic       sat_sticky;
  logic [1:0] sat_count;

  signed_subtractor_pipe #(
    .IN1_WIDTH (8),
    .IN2_WIDTH (8),
    .OUT_WIDTH (8),
    .CNT_WIDTH (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .sat_pos    (sat_pos),
    .sat_neg    (sat_neg),
    .sat_clear  (sat_clear),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic m_sticky = 1'b0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       pos;
    logic       neg;
  } vec_t;

  vec_t vt[7];

  // Reference: exact integer difference, then clamp into [-128, 127].
  function automatic logic [9:0] ref_sub(logic [7:0] x, logic [7:0] y);
    int xi;
    int yi;
    int d;
    xi = $signed(x);
    yi = $signed(y);
    d  = xi - yi;
    if (d > 127) return {8'h7f, 1'b1, 1'b0};
    if (d < -128) return {8'h80, 1'b0, 1'b1};
    return {d[7:0], 1'b0, 1'b0};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge with inputs already set; samples, scores, advances one clock.
  task automatic cycle();
    logic [9:0] e;
    logic evt;
    #1;
    evt = 1'b0;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_out: got out=%0h with no expected result at %0t", out, $time);
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'({out, sat_pos, sat_neg}), 32'(e));
        evt = e[1] | e[0];
      end
    end
    if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b));
    chk("sat_count", 32'(sat_count), 32'(m_cnt));
    chk("sat_sticky", 32'(sat_sticky), 32'(m_sticky));
    if (sat_clear) begin
      m_sticky = evt;
      m_cnt    = evt ? 1 : 0;
    end else if (evt) begin
      m_sticky = 1'b1;
      if (m_cnt < 3) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; sat_clear = 1'b0;

    vt[0] = '{8'd5,   8'd7,   8'hfe, 1'b0, 1'b0};
    vt[1] = '{8'd100, 8'hce,  8'h7f, 1'b1, 1'b0};
    vt[2] = '{8'h9c,  8'd50,  8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h00,  8'h80,  8'h7f, 1'b1, 1'b0};
    vt[4] = '{8'h80,  8'h00,  8'h80, 1'b0, 1'b0};
    vt[5] = '{8'hff,  8'h7f,  8'h80, 1'b0, 1'b0};
    vt[6] = '{8'h7f,  8'hff,  8'h7f, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'({out, sat_pos, sat_neg}), 32'd0);
    chk("rst_count", 32'({sat_sticky, sat_count}), 32'd0);
    reset = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single operands: latency of exactly two edges.
    foreach (vt[i]) begin
      in_valid = 1'b1; a = vt[i].a; b = vt[i].b; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      #1 chk("lat_edge1", 32'(out_valid), 32'd0);
      cycle();
      #1 chk("lat_edge2", 32'(out_valid), 32'd1);
      chk("table_out", 32'({out, sat_pos, sat_neg}), 32'({vt[i].out, vt[i].pos, vt[i].neg}));
      cycle();
    end

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 8'(i * 17 - 20); b = 8'(i * 3);
      #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
      cycle();
    end
    drain(8);

    // Backpressure: two accepted, third refused, head result held stable.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd10; b = 8'd3;
    #1 chk("bp_ready0", 32'(in_ready), 32'd1);
    cycle();
    a = 8'd20; b = 8'hfb;
    #1 chk("bp_ready1", 32'(in_ready), 32'd1);
    cycle();
    a = 8'he2; b = 8'd40;
    #1 chk("bp_ready2", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_hold", 32'({out_valid, out}), 32'({1'b1, 8'd7}));
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    drain(8);

    // Monitor: a saturated result held five cycles is counted once.
    sat_clear = 1'b1;
    cycle();
    sat_clear = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd100; b = 8'hce;
    cycle();
    in_valid = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      #1 chk("sat_held_valid", 32'(out_valid), 32'd1);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    #1 chk("sat_count_once", 32'(sat_count), 32'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = 8'h80; b = 8'(i + 1);
      cycle();
    end
    drain(8);
    #1 chk("sat_count_hold", 32'({sat_sticky, sat_count}), 32'({1'b1, 2'd3}));

    // sat_clear coinciding with a saturated transfer, then alone.
    in_valid = 1'b1; a = 8'h9c; b = 8'd50;
    cycle();
    in_valid = 1'b0;
    cycle();
    #1 chk("clr_evt_valid", 32'(out_valid), 32'd1);
    sat_clear = 1'b1;
    cycle();
    #1 chk("clr_with_evt", 32'({sat_sticky, sat_count}), 32'({1'b1, 2'd1}));
    cycle();
    sat_clear = 1'b0;
    #1 chk("clr_alone", 32'({sat_sticky, sat_count}), 32'd0);

    // Asynchronous reset with both stages full.
    in_valid = 1'b1; a = 8'h00; b = 8'h80;
    cycle();
    drain(8);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd1; b = 8'd2;
    cycle();
    a = 8'd3; b = 8'd4;
    cycle();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 chk("async_rst", 32'({out_valid, sat_sticky, sat_count}), 32'd0);
    exp_q.delete();
    m_cnt = 0;
    m_sticky = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      #1 chk("no_stale", 32'(out_valid), 32'd0);
      cycle();
    end

    // Randomized traffic with extreme-biased operands.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clear = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0: a = 8'h80;
        1: a = 8'h7f;
        default: a = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: b = 8'h80;
        1: b = 8'h7f;
        default: b = 8'($urandom);
      endcase
      cycle();
    end
    sat_clear = 1'b0;
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/signed_subtractor_pipe.md
Name: signed_subtractor_pipe

Overview:
Pipelined saturating signed subtractor, out = a - b, clamped to OUT_WIDTH two's-complement range. It is the subtract-direction counterpart of the saturating signed adder. Used where partial sums are retired or bias/offset is removed before write-back. It has a valid/ready handshake on both sides with full backpressure, per-result saturation flags, and a sticky saturation monitor readable by the controller.

Parameters:
IN1_WIDTH, 32, width of minuend a (signed)
IN2_WIDTH, 32, width of subtrahend b (signed)
OUT_WIDTH, 32, width of result (signed); must be >= 2
CNT_WIDTH, 16, width of saturation event counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block accepts operands this cycle
a  input  IN1_WIDTH  signed minuend
b  input  IN2_WIDTH  signed subtrahend
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  OUT_WIDTH  saturated signed difference
sat_pos  output  1  current out clamped to MAX (qualified by out_valid)
sat_neg  output  1  current out clamped to MIN (qualified by out_valid)
sat_clear  input  1  synchronous clear of sat_sticky and sat_count
sat_sticky  output  1  set by any accepted saturated result
sat_count  output  CNT_WIDTH  number of accepted saturated results, saturating at all-ones

Behaviour:
- Reset (reset==0, async): s1_valid=0, s2_valid=0, out_valid=0, out=0, sat_pos=0, sat_neg=0, sat_sticky=0, sat_count=0. Any in-flight operands are discarded. in_ready=1 once reset deasserts.
- Two register stages.
  - S1 captures a and b, sign-extended to W=max(IN1_WIDTH,IN2_WIDTH,OUT_WIDTH)+1.
  - S2 holds the computed difference after clamping, plus the flags.
- Latency: result valid 2 cycles after the accepting edge when unstalled. Throughput is 1 result per cycle.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid).
  - Transfer happens when valid && ready. Stalled stages hold data and valid unchanged.
  - in_valid may deassert at any time. out_valid never drops without a transfer or reset.
- Arithmetic:
  - d = sext(a) - sext(b), computed in W+1 bits (no internal overflow possible).
  - MAX = 2^(OUT_WIDTH-1)-1 and MIN = -2^(OUT_WIDTH-1).
  - If d > MAX: out=MAX, sat_pos=1. If d < MIN: out=MIN, sat_neg=1. Otherwise out=d[OUT_WIDTH-1:0] with both flags 0.
  - sat_pos and sat_neg are never both 1.
  - Negating MIN counts as overflow: a=0, b=MIN (with IN2_WIDTH==OUT_WIDTH) gives MAX with sat_pos.
- Saturation monitor, updated only on output transfer (out_valid && out_ready) of a result with sat_pos|sat_neg:
  - sat_sticky <= 1.
  - sat_count increments and holds at 2^CNT_WIDTH-1 (no wrap).
  - A stalled saturated result is counted once only.
- sat_clear:
  - With no event that cycle: sticky <= 0, count <= 0.
  - With a saturated transfer in the same cycle: sticky <= 1, count <= 1.
- out, sat_pos and sat_neg are registered. Their values while out_valid==0 are don't-care but must not be X after reset.

Decomposition:
- Shared package:
  - function sat_clamp(value, width) returning the clamped value and pos/neg flags.
  - localparams for MAX/MIN derivation.
  - Width helper max3().
- Sub-module sat_clamp_signed: combinational W+1 to OUT_WIDTH clamp with sat_pos/sat_neg outputs, reusable by the adder.
- Top holds the pipeline registers, handshake and monitor.

Test Plan:
All values use IN1_WIDTH=IN2_WIDTH=OUT_WIDTH=8, CNT_WIDTH=2.
1. a=5, b=7, in_valid for 1 cycle, out_ready=1 -> two edges later out=-2 (0xFE), flags 0, out_valid for 1 cycle. Stream of 4 back-to-back pairs -> 4 consecutive results, in_ready constantly 1.
2. a=100, b=-50 -> out=127, sat_pos=1. a=-100, b=50 -> out=-128, sat_neg=1. a=0, b=-128 -> out=127, sat_pos=1. a=-128, b=0 -> out=-128, no flag.
3. Backpressure: out_ready=0 with 3 pairs offered -> 2 accepted, in_ready=0 on the third. out holds the first result stable. Release out_ready -> results emerge in order, none lost or duplicated.
4. Saturated result held 5 cycles under out_ready=0 -> sat_count=1 after transfer. Four more saturating results -> count holds at 3, sat_sticky=1.
5. sat_clear in the same cycle as a saturated transfer -> sticky=1, count=1. sat_clear alone next cycle -> sticky=0, count=0.
6. Assert reset (0) asynchronously with both stages full -> out_valid, sat_sticky and sat_count drop to 0 immediately. No stale result appears after reset release.
